// File: rtl/wb_dma_master.sv
// wb_dma_master: Wishbone classic-cycle read master that copies a block of 32-bit words
// from Wishbone space into the accelerator SRAM through the memory-controller client port.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   start                  one-cycle transfer request (sampled only when idle)
//   src_addr               Wishbone byte address of the first word (bits [1:0] ignored)
//   dst_addr               SRAM word address of the first word
//   length                 number of words to copy (0 gives an immediate done)
//   busy, done, err        status: transfer active, end-of-transfer pulse, sticky error
//   wbm_*                  Wishbone classic master interface (read-only)
//   mem_op, mem_addr,      memory-controller request (2'b11 write, 2'b00 none)
//   mem_data, mem_opdone   and its completion strobe
module wb_dma_master #(
   parameter int unsigned SRAM_AW = 8,
   parameter int unsigned LEN_W   = 9,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [31:0]        src_addr,
   input  logic [SRAM_AW-1:0] dst_addr,
   input  logic [LEN_W-1:0]   length,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               wbm_cyc_o,
   output logic               wbm_stb_o,
   output logic               wbm_we_o,
   output logic [3:0]         wbm_sel_o,
   output logic [31:0]        wbm_adr_o,
   input  logic [31:0]        wbm_dat_i,
   input  logic               wbm_ack_i,
   input  logic               wbm_err_i,
   output logic [1:0]         mem_op,
   output logic [SRAM_AW-1:0] mem_addr,
   output logic [31:0]        mem_data,
   input  logic               mem_opdone
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [1:0] MemOpNone  = 2'b00;
   localparam logic [1:0] MemOpWrite = 2'b11;

   typedef enum logic [1:0] {StIdle, StWbReq, StMemWr, StDone} state_e;

   state_e             state_q;
   logic [31:0]        src_ptr_q;
   logic [SRAM_AW-1:0] dst_ptr_q;
   logic [LEN_W-1:0]   rem_q;
   logic [TW-1:0]      tmo_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;
   logic               cyc_q;
   logic [1:0]         mem_op_q;
   logic [31:0]        mem_data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         src_ptr_q  <= '0;
         dst_ptr_q  <= '0;
         rem_q      <= '0;
         tmo_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cyc_q      <= 1'b0;
         mem_op_q   <= MemOpNone;
         mem_data_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  err_q <= 1'b0;
                  if (length != '0) begin
                     src_ptr_q <= {src_addr[31:2], 2'b00};
                     dst_ptr_q <= dst_addr;
                     rem_q     <= length;
                     tmo_q     <= '0;
                     busy_q    <= 1'b1;
                     cyc_q     <= 1'b1;
                     state_q   <= StWbReq;
                  end else begin
                     // Empty transfer: report completion without touching either bus.
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end
               end
            end
            StWbReq: begin
               // Slave error beats ack; a late ack on the final timeout cycle still counts.
               if (wbm_err_i) begin
                  err_q   <= 1'b1;
                  cyc_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else if (wbm_ack_i) begin
                  cyc_q      <= 1'b0;
                  mem_op_q   <= MemOpWrite;
                  mem_data_q <= wbm_dat_i;
                  state_q    <= StMemWr;
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  cyc_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            StMemWr: begin
               // mem_opdone is shared with other clients, so only trust it while we request.
               if (mem_opdone && (mem_op_q != MemOpNone)) begin
                  mem_op_q  <= MemOpNone;
                  src_ptr_q <= src_ptr_q + 32'd4;
                  dst_ptr_q <= dst_ptr_q + SRAM_AW'(1);
                  rem_q     <= rem_q - LEN_W'(1);
                  if (rem_q > LEN_W'(1)) begin
                     tmo_q   <= '0;
                     cyc_q   <= 1'b1;
                     state_q <= StWbReq;
                  end else begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;
   assign wbm_we_o  = 1'b0;
   assign wbm_sel_o = 4'hF;
   assign wbm_adr_o = src_ptr_q;
   assign mem_op    = mem_op_q;
   assign mem_addr  = dst_ptr_q;
   assign mem_data  = mem_data_q;

endmodule

// File: tb/tb_wb_dma_master.sv
// Scoreboard bench for wb_dma_master: directed transfers push the expected Wishbone reads,
// SRAM writes and done/err results into a queue; a negedge monitor pops and compares them.
module tb_wb_dma_master;

   localparam int unsigned AW = 8;
   localparam int unsigned LW = 9;
   localparam int unsigned TO = 255;

   localparam int KRd = 1;
   localparam int KWr = 2;
   localparam int KDn = 3;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] d;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [LW-1:0] length = '0;
   logic          busy, done, err;
   logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]    wbm_sel_o;
   logic [31:0]   wbm_adr_o, wbm_dat_i;
   logic          wbm_ack_i, wbm_err_i;
   logic [1:0]    mem_op;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_data;
   logic          mem_opdone = 1'b0;

   // Slave model controls
   logic [31:0]   rd_data [0:7];
   int            rd_total = 0;
   int            rd_base = 0;
   int            rd_idx;
   int            err_idx = -1;
   logic          ack_en = 1'b1;
   logic          err_now;

   int            n_checks = 0;
   int            n_err = 0;
   int            cyc_total = 0;
   int            act_total = 0;
   exp_t          sb[$];

   wb_dma_master #(.SRAM_AW(AW), .LEN_W(LW), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .wbm_cyc_o  (wbm_cyc_o),
      .wbm_stb_o  (wbm_stb_o),
      .wbm_we_o   (wbm_we_o),
      .wbm_sel_o  (wbm_sel_o),
      .wbm_adr_o  (wbm_adr_o),
      .wbm_dat_i  (wbm_dat_i),
      .wbm_ack_i  (wbm_ack_i),
      .wbm_err_i  (wbm_err_i),
      .mem_op     (mem_op),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_opdone (mem_opdone)
   );

   always #5 clk = ~clk;

   // Zero-wait-state slave; data picked by read index within the current test.
   assign rd_idx    = rd_total - rd_base;
   assign err_now   = wbm_cyc_o & wbm_stb_o & (rd_idx == err_idx);
   assign wbm_err_i = err_now;
   assign wbm_ack_i = wbm_cyc_o & wbm_stb_o & ack_en & ~err_now;
   assign wbm_dat_i = rd_data[rd_idx[2:0]];

   always @(posedge clk) begin
      if (wbm_cyc_o && wbm_stb_o && (wbm_ack_i || wbm_err_i)) rd_total <= rd_total + 1;
   end

   // Memory controller: completes a write one cycle after seeing the request.
   always @(posedge clk) begin
      mem_opdone <= (mem_op == 2'b11) && !mem_opdone;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.kind = kind;
      e.a    = a;
      e.d    = d;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input int kind, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_err++;
         $display("FAIL unexpected_event: got kind %0d addr %h data %h expected none",
                  kind, a, d);
      end else begin
         e = sb.pop_front();
         chk("event_kind", 32'(kind), 32'(e.kind));
         if (kind == KRd) chk("wb_adr", a, e.a);
         if (kind == KWr) begin
            chk("mem_addr", a, e.a);
            chk("mem_data", d, e.d);
         end
         if (kind == KDn) chk("done_err", d, e.d);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (wbm_cyc_o) cyc_total <= cyc_total + 1;
         if (wbm_cyc_o || (mem_op != 2'b00)) act_total <= act_total + 1;
         if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) pop_chk(KRd, wbm_adr_o, wbm_dat_i);
         if ((mem_op == 2'b11) && mem_opdone) pop_chk(KWr, 32'(mem_addr), mem_data);
         if (done) pop_chk(KDn, '0, 32'(err));
      end
   end

   task automatic do_start(input logic [31:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
      @(negedge clk);
      rd_base  = rd_total;
      src_addr = s;
      dst_addr = d;
      length   = l;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!seen) begin
         n_err++;
         $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
      end
      @(negedge clk);
      #1;
   endtask

   initial begin
      int c0;
      for (int i = 0; i < 8; i++) rd_data[i] = '0;

      // Reset state
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_cyc", 32'(wbm_cyc_o), 0);
      chk("rst_stb", 32'(wbm_stb_o), 0);
      chk("rst_adr", wbm_adr_o, 0);
      chk("rst_memop", 32'(mem_op), 0);
      chk("rst_memaddr", 32'(mem_addr), 0);
      chk("rst_memdata", mem_data, 0);
      chk("we_const", 32'(wbm_we_o), 0);
      chk("sel_const", 32'(wbm_sel_o), 32'hF);

      // 1: basic 3-word copy, low address bits ignored; start while busy is ignored
      rd_data[0] = 32'hA0; rd_data[1] = 32'hA1; rd_data[2] = 32'hA2;
      push(KRd, 32'h3000_0100, 0); push(KWr, 32'h10, 32'hA0);
      push(KRd, 32'h3000_0104, 0); push(KWr, 32'h11, 32'hA1);
      push(KRd, 32'h3000_0108, 0); push(KWr, 32'h12, 32'hA2);
      push(KDn, 0, 0);
      do_start(32'h3000_0101, 8'h10, 9'd3);
      #1;
      chk("t1_busy", 32'(busy), 1);
      @(negedge clk);
      src_addr = 32'h7000_0000; dst_addr = 8'h77; length = 9'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("t1", 100);
      chk("t1_busy_end", 32'(busy), 0);
      chk("t1_sb_empty", 32'(sb.size()), 0);

      // 2: SRAM address wraps FE, FF, 00 and Wishbone address wraps at 32 bits
      rd_data[0] = 32'h11; rd_data[1] = 32'h22; rd_data[2] = 32'h33;
      push(KRd, 32'hFFFF_FFF8, 0); push(KWr, 32'hFE, 32'h11);
      push(KRd, 32'hFFFF_FFFC, 0); push(KWr, 32'hFF, 32'h22);
      push(KRd, 32'h0000_0000, 0); push(KWr, 32'h00, 32'h33);
      push(KDn, 0, 0);
      do_start(32'hFFFF_FFF8, 8'hFE, 9'd3);
      wait_done("t2", 100);
      chk("t2_sb_empty", 32'(sb.size()), 0);

      // 3: slave error on second read of four
      rd_data[0] = 32'h5; rd_data[1] = 32'h6;
      err_idx = 1;
      push(KRd, 32'h0000_0200, 0); push(KWr, 32'h40, 32'h5);
      push(KDn, 0, 1);
      do_start(32'h0000_0200, 8'h40, 9'd4);
      wait_done("t3", 100);
      err_idx = -1;
      chk("t3_cyc_low", 32'(wbm_cyc_o), 0);
      chk("t3_err_sticky", 32'(err), 1);
      chk("t3_sb_empty", 32'(sb.size()), 0);

      // 5: length 0 gives done next cycle, clears err, no bus activity
      c0 = act_total;
      push(KDn, 0, 0);
      do_start(32'h0000_0300, 8'h00, 9'd0);
      #1;
      chk("t5_done_next", 32'(done), 1);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_err_clr", 32'(err), 0);
      repeat (3) @(negedge clk);
      #1;
      chk("t5_no_activity", 32'(act_total - c0), 0);
      chk("t5_sb_empty", 32'(sb.size()), 0);

      // 4: slave never responds -> cyc held exactly TIMEOUT cycles
      ack_en = 1'b0;
      c0 = cyc_total;
      push(KDn, 0, 1);
      do_start(32'h0000_1000, 8'h00, 9'd2);
      wait_done("t4", 400);
      ack_en = 1'b1;
      chk("t4_cyc_cycles", 32'(cyc_total - c0), 32'(TO));
      chk("t4_err", 32'(err), 1);
      chk("t4_sb_empty", 32'(sb.size()), 0);

      // 6: reset while mem_op=11 abandons the copy without done
      rd_data[0] = 32'h99;
      push(KRd, 32'h0000_0500, 0);
      do_start(32'h0000_0500, 8'h20, 9'd3);
      c0 = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (mem_op == 2'b11) begin
            c0 = 1;
            break;
         end
      end
      chk("t6_saw_write", 32'(c0), 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_memop_rst", 32'(mem_op), 0);
      chk("t6_busy_rst", 32'(busy), 0);
      chk("t6_cyc_rst", 32'(wbm_cyc_o), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("t6_sb_empty", 32'(sb.size()), 0);

      rd_data[0] = 32'hBEEF;
      push(KRd, 32'h0000_0600, 0); push(KWr, 32'h80, 32'hBEEF);
      push(KDn, 0, 0);
      do_start(32'h0000_0600, 8'h80, 9'd1);
      wait_done("t6b", 100);
      chk("t6b_sb_empty", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
